// File: rtl/scan_pkg.sv
// Shared constants and state type for the decoder-line scan generator.
package scan_pkg;
  localparam int unsigned NUM_LINES = 8;
  localparam int unsigned ADDR_W    = 3;

  typedef enum logic [1:0] {
    IDLE,
    DWELL,
    BLANK
  } scan_state_t;
endpackage

// File: rtl/scan_next_idx.sv
// Circular priority search: first set mask bit strictly after cur, wrapping 7->0.
module scan_next_idx
  import scan_pkg::*;
(
  input  logic [NUM_LINES-1:0] mask,
  input  logic [ADDR_W-1:0]    cur,
  output logic [ADDR_W-1:0]    nxt,
  output logic                 found,
  output logic                 wrap
);

  logic [ADDR_W-1:0] idx;

  // Walk from farthest to nearest so the nearest set bit wins; offset 8 is cur itself.
  always_comb begin
    nxt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = NUM_LINES; i >= 1; i--) begin
      idx = ADDR_W'(cur + ADDR_W'(i));
      if (mask[idx]) begin
        nxt   = idx;
        found = 1'b1;
      end
    end
    wrap = found && (nxt <= cur);
  end

endmodule

// File: rtl/scan_addr_gen.sv
// Scans the 3-to-8 decoder address through enabled lines with programmable
// dwell and blanking; all outputs registered.
module scan_addr_gen
  import scan_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 1000,
  parameter int unsigned BLANK_CYCLES = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [NUM_LINES-1:0] mask,
  output logic [ADDR_W-1:0]    addr,
  output logic                 addr_valid,
  output logic                 frame_done,
  output logic                 busy
);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam bit               HAS_BLANK  = (BLANK_CYCLES != 0);

  scan_state_t       state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] search_cur;
  logic [ADDR_W-1:0] nxt;
  logic              found;
  logic              wrap;
  logic              dwell_end;
  logic              line_end;

  // From IDLE, searching after line 7 yields the lowest enabled line.
  assign search_cur = (state == IDLE) ? ADDR_W'(NUM_LINES - 1) : addr;

  scan_next_idx u_next (
    .mask  (mask),
    .cur   (search_cur),
    .nxt   (nxt),
    .found (found),
    .wrap  (wrap)
  );

  assign dwell_end = (state == DWELL) && (cnt == DWELL_LAST);
  assign line_end  = (dwell_end && !HAS_BLANK) ||
                     ((state == BLANK) && (cnt == BLANK_LAST));

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      state      <= IDLE;
      cnt        <= '0;
      addr       <= '0;
      addr_valid <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            state      <= DWELL;
            cnt        <= '0;
            addr       <= nxt;
            addr_valid <= 1'b1;
            busy       <= 1'b1;
          end
        end
        DWELL, BLANK: begin
          if (line_end) begin
            cnt <= '0;
            if (found) begin
              state      <= DWELL;
              addr       <= nxt;
              addr_valid <= 1'b1;
              frame_done <= wrap;
            end else begin
              state      <= IDLE;
              addr       <= '0;
              addr_valid <= 1'b0;
              busy       <= 1'b0;
            end
          end else if (dwell_end) begin
            state      <= BLANK;
            cnt        <= '0;
            addr_valid <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state      <= IDLE;
          cnt        <= '0;
          addr       <= '0;
          addr_valid <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule
